// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache flush engine.
// Holds the tag-entry layout ({dirty, valid, tag}), the field-extract helpers
// and the flush FSM state encoding.
package dcache_pkg;

  localparam int TAG_DIRTY_BIT = 21;
  localparam int TAG_VALID_BIT = 20;
  localparam int TAG_W         = 20;
  localparam int INDEX_W       = 6;
  localparam int LINE_OFFSET_W = 6;
  localparam int TAG_ENTRY_W   = TAG_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CHK  = 3'd2,
    ST_WB   = 3'd3,
    ST_UPD  = 3'd4,
    ST_NEXT = 3'd5,
    ST_DONE = 3'd6
  } flush_state_e;

  function automatic logic entry_dirty(input logic [TAG_ENTRY_W-1:0] e);
    return e[TAG_DIRTY_BIT];
  endfunction

  function automatic logic entry_valid(input logic [TAG_ENTRY_W-1:0] e);
    return e[TAG_VALID_BIT];
  endfunction

  function automatic logic [TAG_W-1:0] entry_tag(input logic [TAG_ENTRY_W-1:0] e);
    return e[TAG_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_flush_engine.sv
// dcache_flush_engine: walks every tag RAM entry, requests a writeback for
// each valid+dirty line, then rewrites the entry clean (or invalid when the
// sweep was started in invalidate mode).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_start_i         start a sweep (sampled in IDLE only)
//   flush_inv_i           invalidate mode, latched with start
//   busy_o, done_o        sweep in progress / one-cycle end-of-sweep pulse
//   tag_addr_o            tag RAM address {tag, index, 0}
//   tag_rdata_i           tag RAM read data {dirty, valid, tag}, 1-cycle latency
//   tag_wr_en_o           tag RAM write enable
//   tag_dirty_o/valid_o   tag RAM write data flags
//   wb_req_o, wb_addr_o   line writeback request and line address
//   wb_ack_i              writeback complete (only honoured while requesting)
//   flushed_cnt_o         lines written back in the last sweep
//
// Build option: define DCACHE_FLUSH_PERF_EN to enable the flushed-line
// counter; otherwise flushed_cnt_o is tied to zero.
module dcache_flush_engine #(
  parameter int TAG_COUNT     = 64,
  parameter int ADDR_WIDTH    = 32,
  parameter int LINE_OFFSET_W = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_start_i,
  input  logic                        flush_inv_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [ADDR_WIDTH-1:0]       tag_addr_o,
  input  logic [21:0]                 tag_rdata_i,
  output logic                        tag_wr_en_o,
  output logic                        tag_dirty_o,
  output logic                        tag_valid_o,
  output logic                        wb_req_o,
  output logic [ADDR_WIDTH-1:0]       wb_addr_o,
  input  logic                        wb_ack_i,
  output logic [$clog2(TAG_COUNT):0]  flushed_cnt_o
);
  import dcache_pkg::*;

  localparam int IDX_W = $clog2(TAG_COUNT);

  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                      input logic [IDX_W-1:0] idx);
    return (ADDR_WIDTH'(tag) << (LINE_OFFSET_W + IDX_W)) |
           (ADDR_WIDTH'(idx) << LINE_OFFSET_W);
  endfunction

  flush_state_e       r_state;
  flush_state_e       w_next;
  logic [IDX_W-1:0]   r_index;
  logic               r_inv;
  logic [TAG_W-1:0]   r_tag;
  logic               w_dirty;
  logic               w_valid;
  logic               w_last;

  assign w_dirty = entry_dirty(tag_rdata_i);
  assign w_valid = entry_valid(tag_rdata_i);
  assign w_last  = (r_index == IDX_W'(TAG_COUNT - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (flush_start_i) w_next = ST_RD;
      ST_RD:   w_next = ST_CHK;
      ST_CHK: begin
        // Invalid entries are skipped even if their dirty bit is set.
        if (w_valid && w_dirty)     w_next = ST_WB;
        else if (w_valid && r_inv)  w_next = ST_UPD;
        else                        w_next = ST_NEXT;
      end
      ST_WB:   if (wb_ack_i) w_next = ST_UPD;
      ST_UPD:  w_next = ST_NEXT;
      ST_NEXT: w_next = w_last ? ST_DONE : ST_RD;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Sweep control: index and latched mode
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_index <= '0;
      r_inv   <= 1'b0;
    end else if (r_state == ST_IDLE && flush_start_i) begin
      r_index <= '0;
      r_inv   <= flush_inv_i;
    end else if (r_state == ST_NEXT && !w_last) begin
      r_index <= r_index + 1'b1;
    end
  end

  // Captured tag is data only; it is consumed solely in WB/UPD after CHK.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_CHK) r_tag <= entry_tag(tag_rdata_i);
  end

  // Output logic
  always_comb begin
    busy_o      = (r_state != ST_IDLE);
    done_o      = 1'b0;
    tag_addr_o  = '0;
    tag_wr_en_o = 1'b0;
    tag_dirty_o = 1'b0;
    tag_valid_o = 1'b0;
    wb_req_o    = 1'b0;
    wb_addr_o   = '0;
    case (r_state)
      // Address stays on the index through CHK/WB so read data is stable.
      ST_RD, ST_CHK: tag_addr_o = line_addr('0, r_index);
      ST_WB: begin
        tag_addr_o = line_addr('0, r_index);
        wb_req_o   = 1'b1;
        wb_addr_o  = line_addr(r_tag, r_index);
      end
      ST_UPD: begin
        // Suppress the write if reset lands on the update cycle.
        tag_wr_en_o = !rst_i;
        tag_addr_o  = line_addr(r_tag, r_index);
        tag_valid_o = !r_inv;
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

`ifdef DCACHE_FLUSH_PERF_EN
  logic [IDX_W:0] r_flushed_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                      r_flushed_cnt <= '0;
    else if (r_state == ST_IDLE && flush_start_i)   r_flushed_cnt <= '0;
    else if (r_state == ST_WB && wb_ack_i)          r_flushed_cnt <= r_flushed_cnt + 1'b1;
  end

  assign flushed_cnt_o = r_flushed_cnt;
`else
  assign flushed_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Testbench for dcache_flush_engine: tag RAM model with 1-cycle read latency,
// writeback responder with programmable ack delay, directed vector table,
// hand-written reset/ignore sequences and randomized sweeps against a
// sweep-level reference model.
module tb_dcache_flush_engine;

  localparam int N = 64;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush_start, flush_inv;
  logic        busy, done, tag_wr_en, tag_dirty, tag_valid, wb_req, wb_ack;
  logic [31:0] tag_addr, wb_addr;
  logic [21:0] tag_rdata;
  logic [6:0]  flushed_cnt;
  logic        ack_resp, ack_stray;

  assign wb_ack = ack_resp | ack_stray;

  dcache_flush_engine dut (
    .clk_i(clk), .rst_i(rst), .flush_start_i(flush_start), .flush_inv_i(flush_inv),
    .busy_o(busy), .done_o(done), .tag_addr_o(tag_addr), .tag_rdata_i(tag_rdata),
    .tag_wr_en_o(tag_wr_en), .tag_dirty_o(tag_dirty), .tag_valid_o(tag_valid),
    .wb_req_o(wb_req), .wb_addr_o(wb_addr), .wb_ack_i(wb_ack),
    .flushed_cnt_o(flushed_cnt)
  );

  // Tag RAM model: synchronous read, write on enable, bulk load from img.
  logic [21:0] mem [N];
  logic [21:0] img [N];
  logic        do_load;

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < N; i++) mem[i] <= img[i];
    end else if (tag_wr_en) begin
      mem[tag_addr[11:6]] <= {tag_dirty, tag_valid, tag_addr[31:12]};
    end
    tag_rdata <= mem[tag_addr[11:6]];
  end

  // Writeback responder: ack after `want` extra WB cycles.
  int  ack_mode;
  bit  ack_hold;
  int  q_used[$];
  int  wcnt, want;

  initial begin
    ack_resp = 1'b0;
    want = -1;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_req && !ack_hold) begin
        if (want < 0) begin
          want = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
          wcnt = 0;
        end
        if (wcnt == want) begin
          ack_resp = 1'b1;
          q_used.push_back(want);
          want = -1;
        end else begin
          ack_resp = 1'b0;
          wcnt++;
        end
      end else begin
        ack_resp = 1'b0;
        if (!wb_req) want = -1;
      end
    end
  end

  int n_chk, n_fail;
  string cur;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", cur, nm, act, exp);
    end
  endtask

  // Observed sweep
  int          cyc, done_cnt, done_cyc, busy_low, busy_after, spurious, unstable;
  logic [31:0] first_addr, prev_wbaddr;
  logic        prev_req;
  logic [31:0] got_wb[$];
  logic [33:0] got_wr[$];

  // Reference model results
  int          exp_done, exp_cnt_last;
  logic [31:0] exp_wb[$];
  logic [33:0] exp_wr[$];
  logic [21:0] exp_fin [N];

  task automatic load_image();
    @(negedge clk);
    do_load = 1'b1;
    @(posedge clk);
    #1 do_load = 1'b0;
  endtask

  task automatic run_sweep(input bit inv, input int mode, input int mid_start_cyc);
    got_wb.delete(); got_wr.delete(); q_used.delete();
    done_cnt = 0; done_cyc = 0; busy_low = 0; busy_after = 0;
    spurious = 0; unstable = 0; prev_req = 1'b0; first_addr = 'x;
    ack_mode = mode;
    @(negedge clk);
    flush_start = 1'b1;
    flush_inv   = inv;
    @(posedge clk);
    #1;
    flush_start = 1'b0;
    flush_inv   = ~inv;   // must already be latched
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) first_addr = tag_addr;
      if (!busy) busy_low++;
      if (wb_req) begin
        if (!prev_req) got_wb.push_back(wb_addr);
        else if (wb_addr !== prev_wbaddr) unstable++;
      end
      prev_req = wb_req;
      prev_wbaddr = wb_addr;
      if (tag_wr_en) got_wr.push_back({tag_addr, tag_dirty, tag_valid});
      else if (tag_dirty || tag_valid) spurious++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      flush_start = (cyc == mid_start_cyc);
    end
    flush_start = 1'b0;
    chk("sweep_finished", (done_cnt != 0), 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0 && busy) busy_after++;
      if (done) done_cnt++;
    end
  endtask

  // Sweep-level model: walk the pre-sweep image with the rules directly.
  task automatic model_sweep(input bit inv);
    int k;
    logic [21:0] e;
    logic [31:0] la;
    exp_wb.delete(); exp_wr.delete();
    exp_done = 1;
    k = 0;
    for (int i = 0; i < N; i++) begin
      e = img[i];
      exp_fin[i] = e;
      exp_done += 3;
      la = {e[19:0], 6'(i), 6'b0};
      if (e[20] && e[21]) begin
        exp_wb.push_back(la);
        exp_done += 2 + ((k < q_used.size()) ? q_used[k] : 0);
        k++;
        exp_wr.push_back({la, 1'b0, !inv});
        exp_fin[i] = {1'b0, !inv, e[19:0]};
      end else if (e[20] && inv) begin
        exp_done += 1;
        exp_wr.push_back({la, 1'b0, !inv});
        exp_fin[i] = {1'b0, !inv, e[19:0]};
      end
    end
  endtask

  task automatic compare_sweep();
    int mis;
    chk("done_cycle", done_cyc, exp_done);
    chk("done_pulses", done_cnt, 1);
    chk("busy_during", busy_low, 0);
    chk("busy_after_done", busy_after, 0);
    chk("wb_addr_stable", unstable, 0);
    chk("flags_outside_upd", spurious, 0);
    chk("first_rd_addr", first_addr, 0);
    chk("wb_count", got_wb.size(), exp_wb.size());
    mis = 0;
    for (int i = 0; i < got_wb.size() && i < exp_wb.size(); i++)
      if (got_wb[i] !== exp_wb[i]) mis++;
    chk("wb_addrs", mis, 0);
    chk("wr_count", got_wr.size(), exp_wr.size());
    mis = 0;
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      if (got_wr[i] !== exp_wr[i]) mis++;
    chk("wr_records", mis, 0);
    mis = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_fin[i]) mis++;
    chk("final_ram", mis, 0);
`ifdef DCACHE_FLUSH_PERF_EN
    exp_cnt_last = exp_wb.size();
`else
    exp_cnt_last = 0;
`endif
    chk("flushed_cnt", flushed_cnt, exp_cnt_last);
  endtask

  typedef struct {
    bit          inv;
    int          idx0;
    logic [21:0] val0;
    int          idx1;
    logic [21:0] val1;
    int          dly;
    int          exp_done;
    int          exp_nwb;
    int          exp_nwr;
    logic [31:0] exp_wb0;
    logic [33:0] exp_wr0;
  } vec_t;

  vec_t vecs[4];

  initial begin
    rst = 1'b1; flush_start = 1'b0; flush_inv = 1'b0; ack_stray = 1'b0;
    ack_hold = 1'b0; ack_mode = 0; do_load = 1'b0; n_chk = 0; n_fail = 0;
    cur = "reset";

    vecs[0] = '{1'b0, 0, 22'h0, 0, 22'h0, 0, 193, 0, 0, 32'h0, 34'h0};
    vecs[1] = '{1'b0, 5, 22'h3ABCDE, 5, 22'h3ABCDE, 3, 198, 1, 1,
                32'hABCDE140, {32'hABCDE140, 2'b01}};
    vecs[2] = '{1'b1, 0, 22'h100001, 63, 22'h3FFFFF, 0, 196, 1, 2,
                32'hFFFFFFC0, {32'h00001000, 2'b00}};
    vecs[3] = '{1'b0, 9, 22'h212345, 9, 22'h212345, 0, 193, 0, 0, 32'h0, 34'h0};

    for (int i = 0; i < N; i++) img[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {busy, done, tag_addr, tag_wr_en, tag_dirty, tag_valid, wb_req, wb_addr, flushed_cnt},
        '0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int v = 0; v < 4; v++) begin
      cur = $sformatf("vec%0d", v);
      for (int i = 0; i < N; i++) img[i] = '0;
      img[vecs[v].idx0] = vecs[v].val0;
      img[vecs[v].idx1] = vecs[v].val1;
      load_image();
      run_sweep(vecs[v].inv, vecs[v].dly, -1);
      model_sweep(vecs[v].inv);
      chk("tbl_done_cycle", done_cyc, vecs[v].exp_done);
      chk("tbl_wb_count", got_wb.size(), vecs[v].exp_nwb);
      chk("tbl_wr_count", got_wr.size(), vecs[v].exp_nwr);
      if (vecs[v].exp_nwb > 0 && got_wb.size() > 0) chk("tbl_wb_addr", got_wb[0], vecs[v].exp_wb0);
      if (vecs[v].exp_nwr > 0 && got_wr.size() > 0) chk("tbl_wr0", got_wr[0], vecs[v].exp_wr0);
      compare_sweep();
    end

    // Reset while WB is waiting on entry 5
    cur = "rst_mid_wb";
    for (int i = 0; i < N; i++) img[i] = '0;
    img[5] = 22'h3ABCDE;
    load_image();
    ack_hold = 1'b1;
    @(negedge clk);
    flush_start = 1'b1; flush_inv = 1'b0;
    @(posedge clk);
    #1 flush_start = 1'b0;
    for (int k = 0; k < 100 && !wb_req; k++) @(negedge clk);
    chk("wb_req_reached", wb_req, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("no_write_in_rst_cycle", tag_wr_en, 0);
    @(posedge clk);
    #1;
    chk("after_rst_outputs",
        {busy, done, tag_addr, tag_wr_en, tag_dirty, tag_valid, wb_req, wb_addr, flushed_cnt},
        '0);
    @(negedge clk);
    rst = 1'b0;
    ack_hold = 1'b0;
    chk("entry5_untouched", mem[5], 22'h3ABCDE);
    run_sweep(1'b0, 1, -1);
    model_sweep(1'b0);
    compare_sweep();

    // Stray ack in IDLE, then a start pulse mid-sweep
    cur = "ignored_inputs";
    @(negedge clk);
    ack_stray = 1'b1;
    @(negedge clk);
    ack_stray = 1'b0;
    chk("idle_after_stray_ack", busy, 0);
    chk("cnt_after_stray_ack", flushed_cnt, exp_cnt_last);
    for (int i = 0; i < N; i++) img[i] = 22'($urandom);
    load_image();
    run_sweep(1'b0, -1, 50);
    model_sweep(1'b0);
    compare_sweep();

    // Randomized sweeps
    for (int r = 0; r < 4; r++) begin
      bit inv;
      cur = $sformatf("rand%0d", r);
      inv = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) img[i] = 22'($urandom);
      load_image();
      run_sweep(inv, -1, -1);
      model_sweep(inv);
      compare_sweep();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
